// File: rtl/dig_display_arbiter.sv
// Fixed-priority arbiter that shares the 8-digit display between three
// requesters, with a minimum hold before preemption and an optional maximum
// hold that forces rotation. All hold limits are counted in tick strobes.
module dig_display_arbiter #(
    parameter logic [7:0]  MIN_HOLD     = 8'd50,
    parameter logic [7:0]  MAX_HOLD     = 8'd250,
    parameter logic [31:0] IDLE_PATTERN = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic [2:0]  gnt,
    output logic [1:0]  owner,
    output logic [3:0]  num0,
    output logic [3:0]  num1,
    output logic [3:0]  num2,
    output logic [3:0]  num3,
    output logic [3:0]  num4,
    output logic [3:0]  num5,
    output logic [3:0]  num6,
    output logic [3:0]  num7
);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [1:0]  owner_q, owner_d;
    logic [31:0] num_q, num_d;
    logic [7:0]  min_cnt_q, min_cnt_d;
    logic [7:0]  max_cnt_q, max_cnt_d;
    logic [2:0]  rot_mask_q, rot_mask_d;

    logic [2:0]  cand;
    logic [1:0]  pick;
    logic [31:0] owner_data;
    logic        grant, leave;

    // Arbitration pick: skip requesters that just timed out unless nobody else wants it
    always_comb begin
        cand = req & ~rot_mask_q;
        if (cand == 3'b000) cand = req;
        if (cand[0])      pick = 2'd0;
        else if (cand[1]) pick = 2'd1;
        else              pick = 2'd2;
    end

    // Live data of the current owner
    always_comb begin
        case (owner_q)
            2'd0:    owner_data = data0;
            2'd1:    owner_data = data1;
            2'd2:    owner_data = data2;
            default: owner_data = num_q;
        endcase
    end

    // Next-state, grant and counter logic
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        num_d      = num_q;
        min_cnt_d  = min_cnt_q;
        max_cnt_d  = max_cnt_q;
        rot_mask_d = rot_mask_q;
        grant      = 1'b0;
        leave      = 1'b0;

        case (state_q)
            S_IDLE: begin
                num_d = IDLE_PATTERN;
                if (req != 3'b000) grant = 1'b1;
            end
            S_GAP: begin
                // num keeps its last value through the gap
                if (req != 3'b000) grant = 1'b1;
                else               state_d = S_IDLE;
            end
            S_OWN: begin
                num_d = owner_data;
                if ((req & gnt_q) == 3'b000) begin
                    leave = 1'b1;
                end else if (MAX_HOLD != 8'd0 && max_cnt_q == 8'd0) begin
                    leave      = 1'b1;
                    rot_mask_d = rot_mask_q | gnt_q;
                end else if (min_cnt_q == 8'd0 && (req & (gnt_q - 3'd1)) != 3'b000) begin
                    // gnt-1 masks exactly the higher-priority (lower-index) bits
                    leave = 1'b1;
                end else if (tick) begin
                    if (min_cnt_q != 8'd0) min_cnt_d = min_cnt_q - 8'd1;
                    if (MAX_HOLD != 8'd0 && max_cnt_q != 8'd0) max_cnt_d = max_cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (grant) begin
            state_d    = S_OWN;
            gnt_d      = 3'b001 << pick;
            owner_d    = pick;
            min_cnt_d  = MIN_HOLD;
            max_cnt_d  = MAX_HOLD;
            rot_mask_d = 3'b000;
        end
        if (leave) begin
            state_d = S_GAP;
            gnt_d   = 3'b000;
            owner_d = 2'd3;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= 3'b000;
            owner_q    <= 2'd3;
            num_q      <= IDLE_PATTERN;
            min_cnt_q  <= 8'd0;
            max_cnt_q  <= 8'd0;
            rot_mask_q <= 3'b000;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            num_q      <= num_d;
            min_cnt_q  <= min_cnt_d;
            max_cnt_q  <= max_cnt_d;
            rot_mask_q <= rot_mask_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign num0  = num_q[3:0];
    assign num1  = num_q[7:4];
    assign num2  = num_q[11:8];
    assign num3  = num_q[15:12];
    assign num4  = num_q[19:16];
    assign num5  = num_q[23:20];
    assign num6  = num_q[27:24];
    assign num7  = num_q[31:28];

endmodule
